// File: rtl/mem_1r1w_fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_1r1w_fifo_ctrl_pkg
// Purpose : shared sizing constants, typedefs and the pointer-wrap helper for
//           the FIFO controller in front of the 48x64 mem_1r1w macro wrapper.
//           Values must stay identical to the mem_1r1w configuration.
// Contents: DEPTH, WIDTH, ADDR_W, CNT_W, ptr_t, cnt_t, data_t, inc_wrap().
// ---------------------------------------------------------------------------
package mem_1r1w_fifo_ctrl_pkg;

  localparam int DEPTH  = 48;  // memory entries, not a power of two
  localparam int WIDTH  = 64;  // data width
  localparam int ADDR_W = 6;   // 2**ADDR_W >= DEPTH
  localparam int CNT_W  = 6;   // holds DEPTH + 2 (mem + in-flight + prefetch)

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [WIDTH-1:0]  data_t;

  // Pointers cannot rely on natural binary rollover because DEPTH is not a
  // power of two, so the last legal index wraps explicitly to zero.
  function automatic ptr_t inc_wrap(input ptr_t ptr, input int depth);
    if (int'(ptr) == depth - 1) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/mem_1r1w_fifo_ctrl_prefetch.sv
// ---------------------------------------------------------------------------
// fifo_prefetch_buf
// Purpose : 2-entry register queue that catches read data returning from the
//           memory so the FIFO head is always driven from a flop.
// Ports   : i_clk        clock
//           i_rst_n      asynchronous active-low reset
//           i_flush      synchronous clear of entries and count
//           i_push       write i_push_data at the tail this edge
//           i_push_data  data returning from the memory
//           i_pop        remove the head this edge (only while o_cnt != 0)
//           o_head       head entry (registered)
//           o_cnt        number of valid entries, 0..2
// ---------------------------------------------------------------------------
module fifo_prefetch_buf
  import mem_1r1w_fifo_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  data_t      i_push_data,
  input  logic       i_pop,
  output data_t      o_head,
  output logic [1:0] o_cnt
);

  data_t      r_entry [2];  // [0] is always the head
  logic [1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_entry[0] <= '0;
      r_entry[1] <= '0;
      r_cnt      <= '0;
    end else if (i_flush) begin
      r_entry[0] <= '0;
      r_entry[1] <= '0;
      r_cnt      <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_entry[0] <= i_push_data;
          else               r_entry[1] <= i_push_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_entry[0] <= r_entry[1];
          r_cnt      <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (r_cnt == 2'd2) begin
            r_entry[0] <= r_entry[1];
            r_entry[1] <= i_push_data;
          end else begin
            r_entry[0] <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // The read-issue throttle upstream guarantees this never fires.
  always @(posedge i_clk) begin
    if (i_rst_n && !i_flush) begin
      assert (!(i_push && !i_pop && (r_cnt == 2'd2)))
        else $error("fifo_prefetch_buf overflow");
    end
  end

  assign o_head = r_entry[0];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/mem_1r1w_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// mem_1r1w_fifo_ctrl
// Purpose : synchronous FIFO controller driving the 48x64 1R1W memory macro
//           wrapper mem_1r1w. Owns write/read pointers and occupancy, issues
//           one-cycle-latency reads and holds up to two returned words in a
//           prefetch buffer so deq_data is registered.
// Ports   : clock, reset_n (async, active-low), flush (sync clear)
//           enq_valid/enq_ready/enq_data      producer side
//           deq_valid/deq_ready/deq_data      consumer side
//           count                             mem + in-flight + prefetch
//           W0_addr/W0_en/W0_data             memory write port
//           R0_addr/R0_en/R0_data             memory read port (data +1 cycle)
// ---------------------------------------------------------------------------
module mem_1r1w_fifo_ctrl
  import mem_1r1w_fifo_ctrl_pkg::*;
(
  input  logic  clock,
  input  logic  reset_n,
  input  logic  flush,
  input  logic  enq_valid,
  output logic  enq_ready,
  input  data_t enq_data,
  output logic  deq_valid,
  input  logic  deq_ready,
  output data_t deq_data,
  output cnt_t  count,
  output ptr_t  W0_addr,
  output logic  W0_en,
  output data_t W0_data,
  output ptr_t  R0_addr,
  output logic  R0_en,
  input  data_t R0_data
);

  ptr_t r_wptr;
  ptr_t r_rptr;
  cnt_t r_mem_cnt;
  logic r_inflight;
  cnt_t r_count;

  logic       w_enq_fire;
  logic       w_deq_fire;
  logic       w_rd;
  logic       w_pf_push;
  logic [1:0] w_pf_cnt;
  logic [1:0] w_pf_cnt_next;
  logic [2:0] w_rd_occ;
  cnt_t       w_mem_cnt_next;
  data_t      w_pf_head;

  // Full is judged on memory occupancy only; a same-cycle dequeue does not
  // open a slot because there is no pass-through path.
  assign enq_ready  = (r_mem_cnt != cnt_t'(DEPTH));
  assign w_enq_fire = enq_valid & enq_ready;

  assign deq_valid  = (w_pf_cnt != 2'd0);
  assign w_deq_fire = deq_valid & deq_ready;
  assign deq_data   = w_pf_head;

  // Issue a read only if the word will have a prefetch slot when it returns:
  // pf_cnt + inflight - deq_fire < 2, rearranged to avoid underflow.
  assign w_rd_occ = {1'b0, w_pf_cnt} + {2'b00, r_inflight};
  assign w_rd     = (r_mem_cnt != '0) && (w_rd_occ < (3'd2 + {2'b00, w_deq_fire}));

  assign W0_en   = w_enq_fire;
  assign W0_addr = r_wptr;
  assign W0_data = enq_data;
  assign R0_en   = w_rd;
  assign R0_addr = r_rptr;

  assign w_pf_push      = r_inflight;
  assign w_mem_cnt_next = r_mem_cnt + cnt_t'(w_enq_fire) - cnt_t'(w_rd);
  assign w_pf_cnt_next  = w_pf_cnt + {1'b0, w_pf_push} - {1'b0, w_deq_fire};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
    end else if (flush) begin
      // Clearing inflight here is what discards the read data returning in
      // the cycle after the flush.
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_enq_fire) r_wptr <= inc_wrap(r_wptr, DEPTH);
      if (w_rd)       r_rptr <= inc_wrap(r_rptr, DEPTH);
      r_mem_cnt  <= w_mem_cnt_next;
      r_inflight <= w_rd;
      r_count    <= w_mem_cnt_next + cnt_t'(w_rd) + cnt_t'(w_pf_cnt_next);
    end
  end

  assign count = r_count;

  fifo_prefetch_buf u_pf (
    .i_clk       (clock),
    .i_rst_n     (reset_n),
    .i_flush     (flush),
    .i_push      (w_pf_push),
    .i_push_data (R0_data),
    .i_pop       (w_deq_fire),
    .o_head      (w_pf_head),
    .o_cnt       (w_pf_cnt)
  );

endmodule
